uart_fifo_bridge: RTL and testbench

//  Buffered MMIO bridge between the CPU datapath's UART handshake and the UART serial core.
//  - TX FIFO: absorbs CPU store bytes (DataIn/DataInValid).
//  - RX FIFO: holds received bytes until the CPU loads them (DataOut/DataOutReady).
//  - Decouples CPU polling from UART bit timing; status bits feed the datapath UART read mux.

---
 rtl/uart_fifo_bridge.sv | 154 +++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// Buffered MMIO bridge: CPU byte stream <-> TX/RX FIFOs <-> UART serial core.
// Optional internal TX->RX loopback path when UART_LOOPBACK_EN is defined.

module uart_fifo_bridge_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    // Full/empty come only from the registered count, so a push is never
    // accepted on a full FIFO and a pop never fires on an empty one.
    assign o_full  = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end
endmodule

module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic             CLK,
    input  logic             reset_n,
`ifdef UART_LOOPBACK_EN
    input  logic             loopback,
`endif
    input  logic [WIDTH-1:0] DataIn,
    input  logic             DataInValid,
    output logic             DataInReady,
    output logic [WIDTH-1:0] DataOut,
    output logic             DataOutValid,
    input  logic             DataOutReady,
    output logic [WIDTH-1:0] uart_tx_data,
    output logic             uart_tx_valid,
    input  logic             uart_tx_ready,
    input  logic [WIDTH-1:0] uart_rx_data,
    input  logic             uart_rx_valid,
    output logic             uart_rx_ready,
    output logic             tx_drop,
    input  logic             clear_flags
);
    logic             w_loopback;
    logic [WIDTH-1:0] w_tx_head;
    logic [WIDTH-1:0] w_rx_head;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic             w_lb_move;
    logic             w_tx_pop;
    logic             w_rx_push;
    logic [WIDTH-1:0] w_rx_push_data;
    logic             r_tx_drop;

`ifdef UART_LOOPBACK_EN
    assign w_loopback = loopback;
`else
    assign w_loopback = 1'b0;
`endif

    // In loopback the TX head is moved straight into RX, one byte per cycle,
    // and the UART handshakes are held off.
    assign w_lb_move      = w_loopback & ~w_tx_empty & ~w_rx_full;
    assign w_tx_pop       = w_loopback ? w_lb_move : uart_tx_ready;
    assign w_rx_push      = w_loopback ? w_lb_move : uart_rx_valid;
    assign w_rx_push_data = w_loopback ? w_tx_head : uart_rx_data;

    uart_fifo_bridge_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_tx_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .i_push  (DataInValid),
        .i_data  (DataIn),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    uart_fifo_bridge_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_rx_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .i_push  (w_rx_push),
        .i_data  (w_rx_push_data),
        .i_pop   (DataOutReady),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // A dropped write in the same cycle as clear_flags keeps the flag set.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)
            r_tx_drop <= 1'b0;
        else if (DataInValid && w_tx_full)
            r_tx_drop <= 1'b1;
        else if (clear_flags)
            r_tx_drop <= 1'b0;
    end

    assign DataInReady   = ~w_tx_full;
    assign DataOut       = w_rx_head;
    assign DataOutValid  = ~w_rx_empty;
    assign uart_tx_data  = w_tx_head;
    assign uart_tx_valid = ~w_tx_empty & ~w_loopback;
    assign uart_rx_ready = ~w_rx_full & ~w_loopback;
    assign tx_drop       = r_tx_drop;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: stimulus pushes expected bytes into
// queues, a negedge monitor pops and compares on every accepted handshake.
module tb_uart_fifo_bridge;
    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] DataIn = '0;
    logic       DataInValid = 1'b0;
    logic       DataInReady;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       DataOutReady = 1'b0;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready = 1'b0;
    logic [7:0] uart_rx_data = '0;
    logic       uart_rx_valid = 1'b0;
    logic       uart_rx_ready;
    logic       tx_drop;
    logic       clear_flags = 1'b0;
`ifdef UART_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] txExpQ[$];
    logic [7:0] rxExpQ[$];

    uart_fifo_bridge dut (
        .CLK           (CLK),
        .reset_n       (reset_n),
`ifdef UART_LOOPBACK_EN
        .loopback      (loopback),
`endif
        .DataIn        (DataIn),
        .DataInValid   (DataInValid),
        .DataInReady   (DataInReady),
        .DataOut       (DataOut),
        .DataOutValid  (DataOutValid),
        .DataOutReady  (DataOutReady),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .tx_drop       (tx_drop),
        .clear_flags   (clear_flags)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and are held for one cycle.
    task automatic applyStimulus(input logic dinValid, input logic [7:0] din, input logic txReady,
                                 input logic rxValid, input logic [7:0] rxData,
                                 input logic doutReady, input logic clr);
        DataInValid   = dinValid;
        DataIn        = din;
        uart_tx_ready = txReady;
        uart_rx_valid = rxValid;
        uart_rx_data  = rxData;
        DataOutReady  = doutReady;
        clear_flags   = clr;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge CLK) begin
        if (reset_n) begin
            if (uart_tx_valid && uart_tx_ready) begin
                if (txExpQ.size() == 0) begin
                    checkOutput("tx_unexpected", {8'h0, uart_tx_data}, 16'hFFFF);
                end else begin
                    checkOutput("tx_byte", {8'h0, uart_tx_data}, {8'h0, txExpQ.pop_front()});
                end
            end
            if (DataOutValid && DataOutReady) begin
                if (rxExpQ.size() == 0) begin
                    checkOutput("rx_unexpected", {8'h0, DataOut}, 16'hFFFF);
                end else begin
                    checkOutput("rx_byte", {8'h0, DataOut}, {8'h0, rxExpQ.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values
        #12;
        checkOutput("rst_DataInReady", DataInReady, 1);
        checkOutput("rst_uart_rx_ready", uart_rx_ready, 1);
        checkOutput("rst_DataOutValid", DataOutValid, 0);
        checkOutput("rst_uart_tx_valid", uart_tx_valid, 0);
        checkOutput("rst_tx_drop", tx_drop, 0);
        checkOutput("rst_DataOut", DataOut, 0);
        checkOutput("rst_uart_tx_data", uart_tx_data, 0);
        @(posedge CLK);
        #1 reset_n = 1'b1;

        // Two CPU writes, transmitter stalled then released
        applyStimulus(1, 8'h41, 0, 0, 0, 0, 0);
        txExpQ.push_back(8'h41);
        checkOutput("t2_tx_valid", uart_tx_valid, 1);
        checkOutput("t2_tx_head", uart_tx_data, 8'h41);
        applyStimulus(1, 8'h42, 0, 0, 0, 0, 0);
        txExpQ.push_back(8'h42);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("t2_tx_valid_after", uart_tx_valid, 0);

        // Fill TX, overflow write, sticky drop flag
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'(i), 0, 0, 0, 0, 0);
            txExpQ.push_back(8'(i));
        end
        checkOutput("t3_full_ready", DataInReady, 0);
        checkOutput("t3_no_drop_yet", tx_drop, 0);
        applyStimulus(1, 8'h08, 0, 0, 0, 0, 0);
        checkOutput("t3_drop_set", tx_drop, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("t3_drop_clear", tx_drop, 0);
        applyStimulus(1, 8'h09, 0, 0, 0, 0, 1);
        checkOutput("t3_set_wins", tx_drop, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("t3_drop_clear2", tx_drop, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("t3_drained_valid", uart_tx_valid, 0);
        checkOutput("t3_drained_ready", DataInReady, 1);

        // RX at 7 entries: push and pop together
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 0, 1, 8'h60 + 8'(i), 0, 0);
            rxExpQ.push_back(8'h60 + 8'(i));
        end
        applyStimulus(0, 0, 0, 1, 8'h55, 1, 0);
        rxExpQ.push_back(8'h55);
        checkOutput("t4_rx_ready", uart_rx_ready, 1);
        checkOutput("t4_head_adv", DataOut, 8'h61);
        applyStimulus(0, 0, 0, 1, 8'h67, 0, 0);
        rxExpQ.push_back(8'h67);
        checkOutput("t4_rx_full", uart_rx_ready, 0);
        applyStimulus(0, 0, 0, 1, 8'hEE, 1, 0);
        checkOutput("t4_full_pop_only", uart_rx_ready, 1);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("t4_empty_valid", DataOutValid, 0);
        checkOutput("t4_empty_data", DataOut, 0);

        // Empty RX: push and pop in the same cycle pushes only
        applyStimulus(0, 0, 0, 1, 8'hA5, 1, 0);
        rxExpQ.push_back(8'hA5);
        checkOutput("t5_valid", DataOutValid, 1);
        checkOutput("t5_data", DataOut, 8'hA5);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_empty", DataOutValid, 0);

        // Reset mid-operation discards buffered bytes
        applyStimulus(1, 8'h77, 0, 1, 8'h88, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_tx_valid", uart_tx_valid, 0);
        checkOutput("rst_mid_rx_valid", DataOutValid, 0);
        @(posedge CLK);
        #1 reset_n = 1'b1;
        applyStimulus(0, 0, 1, 0, 0, 1, 0);
        checkOutput("rst_mid_still_empty", uart_tx_valid, 0);

`ifdef UART_LOOPBACK_EN
        loopback = 1'b1;
        applyStimulus(1, 8'h10, 0, 0, 0, 0, 0);
        rxExpQ.push_back(8'h10);
        checkOutput("t6_tx_valid0", uart_tx_valid, 0);
        applyStimulus(1, 8'h20, 0, 0, 0, 0, 0);
        rxExpQ.push_back(8'h20);
        checkOutput("t6_tx_valid1", uart_tx_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_rx_head", DataOut, 8'h10);
        checkOutput("t6_rx_ready", uart_rx_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        loopback = 1'b0;
`endif

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("tx_queue_drained", 16'(txExpQ.size()), 0);
        checkOutput("rx_queue_drained", 16'(rxExpQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
